// File: rtl/trng_pkg.sv
// trng_pkg: shared defaults, width helpers and pair-state type for the
// TRNG post-processing path (von Neumann debias + word packer).
package trng_pkg;

    localparam int TRNG_WORD_WIDTH_DEF = 32;
    localparam int TRNG_RCT_CUTOFF_DEF = 32;

    // Width of the packer bit count, which must hold 0..word_width inclusive.
    function automatic int cnt_width(input int word_width);
        return $clog2(word_width + 1);
    endfunction

    // Width of the repetition run counter, which saturates at cutoff.
    function automatic int rct_width(input int cutoff);
        return $clog2(cutoff + 1);
    endfunction

    // Von Neumann pair tracking: empty, or holding the first bit of a pair.
    typedef enum logic {
        PAIR_EMPTY = 1'b0,
        PAIR_FULL  = 1'b1
    } pair_state_t;

endpackage

// File: rtl/trng_vn_debias.sv
// trng_vn_debias: optional von Neumann extractor in front of the packer.
//
// state      | meaning
// -----------+-----------------------------------------------
// PAIR_EMPTY | no bit stored, next accepted bit opens a pair
// PAIR_FULL  | first bit of a pair stored in r_first
//
// The emitted bit is combinational so raw pass-through and the pair-closing
// bit both reach the packer in the cycle they are accepted.
module trng_vn_debias
    import trng_pkg::*;
(
    input  logic clk,
    input  logic rst_i,
    input  logic en_i,
    input  logic vn_en_i,
    input  logic bit_i,
    input  logic bit_valid_i,
    output logic bit_o,
    output logic bit_valid_o
);

    pair_state_t r_state;
    logic        r_first;
    logic        w_accept;

    assign w_accept = en_i && bit_valid_i;

    // Pair FSM: open a pair on the first bit, close it on the second; disabled
    // extractor or accept enable always returns to empty.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            r_state <= PAIR_EMPTY;
            r_first <= 1'b0;
        end else if (!en_i || !vn_en_i) begin
            r_state <= PAIR_EMPTY;
        end else if (bit_valid_i) begin
            if (r_state == PAIR_EMPTY) begin
                r_first <= bit_i;
                r_state <= PAIR_FULL;
            end else begin
                r_state <= PAIR_EMPTY;
            end
        end
    end

    // Emit: raw bit when bypassed, else the first bit of an unequal pair.
    always_comb begin
        bit_o       = vn_en_i ? r_first : bit_i;
        bit_valid_o = w_accept &&
                      (!vn_en_i || ((r_state == PAIR_FULL) && (bit_i != r_first)));
    end

endmodule

// File: rtl/trng_word_packer.sv
// trng_word_packer: packs debiased random bits MSB-first into words offered
// over valid/ready, with a one-word accumulator behind the output register.
// Optional feature macro: TRNG_HEALTH_TEST_EN (repetition-count alarm on the
// raw accepted bits; when set, new bits stop entering the packer).
module trng_word_packer
    import trng_pkg::*;
#(
    parameter int WORD_WIDTH = TRNG_WORD_WIDTH_DEF,
    parameter int RCT_CUTOFF = TRNG_RCT_CUTOFF_DEF
) (
    input  logic                  clk,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic                  bit_i,
    input  logic                  bit_valid_i,
    input  logic                  vn_en_i,
    input  logic                  clear_i,
    output logic [WORD_WIDTH-1:0] word_o,
    output logic                  word_valid_o,
    input  logic                  word_ready_i,
    output logic                  overflow_o,
    output logic                  alarm_o
);

    localparam int              CNT_W     = cnt_width(WORD_WIDTH);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORD_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_WIDTH - 1);

    generate
        if (WORD_WIDTH < 2 || RCT_CUTOFF < 2) begin : g_bad_param
            $error("trng_word_packer: WORD_WIDTH and RCT_CUTOFF must be >= 2");
        end
    endgenerate

    logic                  w_db_bit;
    logic                  w_db_valid;
    logic                  w_suppress;
    logic                  w_emit;
    logic                  w_out_free;
    logic [WORD_WIDTH-1:0] w_acc_shift;

    logic [WORD_WIDTH-1:0] r_acc;
    logic [CNT_W-1:0]      r_cnt;
    logic [WORD_WIDTH-1:0] r_word;
    logic                  r_word_valid;
    logic                  r_overflow;

    trng_vn_debias u_debias (
        .clk        (clk),
        .rst_i      (rst_i),
        .en_i       (en_i),
        .vn_en_i    (vn_en_i),
        .bit_i      (bit_i),
        .bit_valid_i(bit_valid_i),
        .bit_o      (w_db_bit),
        .bit_valid_o(w_db_valid)
    );

`ifdef TRNG_HEALTH_TEST_EN
    localparam int               RUN_W   = rct_width(RCT_CUTOFF);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(RCT_CUTOFF);

    logic             w_accept;
    logic [RUN_W-1:0] w_run_next;
    logic [RUN_W-1:0] r_run;
    logic             r_last;
    logic             r_alarm;

    assign w_accept = en_i && bit_valid_i;

    // Next run length on the raw stream: restart on a change, saturate at cutoff.
    always_comb begin
        w_run_next = r_run;
        if (w_accept) begin
            if ((r_run == '0) || (bit_i != r_last)) begin
                w_run_next = RUN_W'(1);
            end else if (r_run != RUN_MAX) begin
                w_run_next = r_run + RUN_W'(1);
            end
        end
    end

    // Run counter and sticky alarm; clear wins over a trip in the same cycle.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            r_run   <= '0;
            r_last  <= 1'b0;
            r_alarm <= 1'b0;
        end else begin
            if (w_accept) begin
                r_last <= bit_i;
            end
            if (clear_i) begin
                r_run   <= '0;
                r_alarm <= 1'b0;
            end else begin
                r_run <= w_run_next;
                if (w_run_next == RUN_MAX) begin
                    r_alarm <= 1'b1;
                end
            end
        end
    end

    assign w_suppress = r_alarm;
    assign alarm_o    = r_alarm;
`else
    assign w_suppress = 1'b0;
    assign alarm_o    = 1'b0;
`endif

    assign w_emit      = w_db_valid && !w_suppress;
    assign w_out_free  = !r_word_valid || word_ready_i;
    assign w_acc_shift = {r_acc[WORD_WIDTH-2:0], w_db_bit};

    // Packer: shift bits into acc, move completed words to the output register
    // when it is free, and drop bits only when both acc and output are full.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            r_acc        <= '0;
            r_cnt        <= '0;
            r_word       <= '0;
            r_word_valid <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            if (r_word_valid && word_ready_i) begin
                r_word_valid <= 1'b0;
            end
            if (clear_i) begin
                r_overflow <= 1'b0;
            end

            if (r_cnt == CNT_FULL) begin
                if (w_out_free) begin
                    r_word       <= r_acc;
                    r_word_valid <= 1'b1;
                    if (w_emit) begin
                        r_acc <= w_acc_shift;
                        r_cnt <= CNT_W'(1);
                    end else begin
                        r_cnt <= '0;
                    end
                end else if (w_emit && !clear_i) begin
                    r_overflow <= 1'b1;
                end
            end else if (w_emit) begin
                if ((r_cnt == CNT_LAST) && w_out_free) begin
                    r_word       <= w_acc_shift;
                    r_word_valid <= 1'b1;
                    r_cnt        <= '0;
                end else begin
                    r_acc <= w_acc_shift;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign word_o       = r_word;
    assign word_valid_o = r_word_valid;
    assign overflow_o   = r_overflow;

endmodule

// File: tb/tb_trng_word_packer.sv
// tb_trng_word_packer: randomized and directed checks of trng_word_packer
// against a queue-based reference model of the bit stream.
module tb_trng_word_packer;

    localparam int W   = 32;
    localparam int CUT = 32;

    logic         clk = 1'b0;
    logic         rst_i;
    logic         en_i;
    logic         bit_i;
    logic         bit_valid_i;
    logic         vn_en_i;
    logic         clear_i;
    logic [W-1:0] word_o;
    logic         word_valid_o;
    logic         word_ready_i;
    logic         overflow_o;
    logic         alarm_o;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    bit       m_acc[$];
    bit [W-1:0] m_word;
    bit       m_valid, m_ovf, m_alarm, m_pf, m_pb, m_last;
    int       m_run;

    always #5 clk = ~clk;

    trng_word_packer #(.WORD_WIDTH(W), .RCT_CUTOFF(CUT)) dut (
        .clk         (clk),
        .rst_i       (rst_i),
        .en_i        (en_i),
        .bit_i       (bit_i),
        .bit_valid_i (bit_valid_i),
        .vn_en_i     (vn_en_i),
        .clear_i     (clear_i),
        .word_o      (word_o),
        .word_valid_o(word_valid_o),
        .word_ready_i(word_ready_i),
        .overflow_o  (overflow_o),
        .alarm_o     (alarm_o)
    );

    task automatic model_reset();
        m_acc.delete();
        m_word = '0; m_valid = 0; m_ovf = 0; m_alarm = 0;
        m_pf = 0; m_pb = 0; m_last = 0; m_run = 0;
    endtask

    function automatic bit [W-1:0] pack_acc();
        bit [W-1:0] w;
        for (int i = 0; i < W; i++) w[W-1-i] = m_acc[i];
        return w;
    endfunction

    // One clock of the stream-level model, using the inputs present at the edge.
    task automatic model_step();
        bit acc_ok, emit, eb, free, ovf_set, alarm_old;
        if (rst_i) begin model_reset(); return; end
        acc_ok = en_i && bit_valid_i;
        emit = 0; eb = 0; ovf_set = 0;
        alarm_old = m_alarm;
        if (acc_ok && !vn_en_i) begin
            emit = 1; eb = bit_i;
        end else if (acc_ok) begin
            if (!m_pf) begin m_pf = 1; m_pb = bit_i; end
            else begin
                if (bit_i != m_pb) begin emit = 1; eb = m_pb; end
                m_pf = 0;
            end
        end
        if (!en_i || !vn_en_i) m_pf = 0;
`ifdef TRNG_HEALTH_TEST_EN
        if (acc_ok) begin
            if (m_run == 0 || bit_i != m_last) m_run = 1;
            else if (m_run < CUT) m_run++;
            m_last = bit_i;
        end
        if (m_run == CUT) m_alarm = 1;
        if (clear_i) begin m_run = 0; m_alarm = 0; end
`endif
        if (alarm_old) emit = 0;
        free = !m_valid || word_ready_i;
        if (m_valid && word_ready_i) m_valid = 0;
        if (free && m_acc.size() == W) begin
            m_word = pack_acc(); m_acc.delete(); m_valid = 1; free = 0;
        end
        if (emit) begin
            if (m_acc.size() == W) ovf_set = 1;
            else begin
                m_acc.push_back(eb);
                if (m_acc.size() == W && free) begin
                    m_word = pack_acc(); m_acc.delete(); m_valid = 1;
                end
            end
        end
        if (clear_i) m_ovf = 0;
        else if (ovf_set) m_ovf = 1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive(input logic a_en, a_bv, a_b, a_vn, a_rdy, a_clr);
        en_i = a_en; bit_valid_i = a_bv; bit_i = a_b;
        vn_en_i = a_vn; word_ready_i = a_rdy; clear_i = a_clr;
    endtask

    task automatic test_reset();
        n_cmp++;
        if (word_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", word_valid_o); end
        n_cmp++;
        if (word_o !== '0) begin n_bad++; $display("FAIL reset_word got %h want 0", word_o); end
        n_cmp++;
        if (overflow_o !== 1'b0) begin n_bad++; $display("FAIL reset_ovf got %b want 0", overflow_o); end
        n_cmp++;
        if (alarm_o !== 1'b0) begin n_bad++; $display("FAIL reset_alarm got %b want 0", alarm_o); end
    endtask

    task automatic test_raw_pack();
        for (int i = 0; i < 32; i++) begin
            drive(1, 1, (i % 4) != 1, 0, 1, 0);
            tick();
            n_cmp++;
            if ({word_valid_o, overflow_o, alarm_o} !== {m_valid, m_ovf, m_alarm}) begin
                n_bad++; $display("FAIL raw_flags cyc %0d got %b%b%b want %b%b%b", i,
                    word_valid_o, overflow_o, alarm_o, m_valid, m_ovf, m_alarm);
            end
        end
        n_cmp++;
        if (word_valid_o !== 1'b1 || word_o !== 32'hBBBBBBBB) begin
            n_bad++; $display("FAIL raw_word got v=%b %h want v=1 bbbbbbbb", word_valid_o, word_o);
        end
        drive(1, 0, 0, 0, 1, 0);
        tick();
        n_cmp++;
        if (word_valid_o !== 1'b0) begin n_bad++; $display("FAIL raw_one_cycle got %b want 0", word_valid_o); end
    endtask

    task automatic test_debias();
        bit pairs [10] = '{0,1, 1,0, 0,0, 1,1, 1,0};
        for (int i = 0; i < 10; i++) begin
            drive(1, 1, pairs[i], 1, 1, 0);
            tick();
            n_cmp++;
            if (word_valid_o !== m_valid) begin
                n_bad++; $display("FAIL vn_valid cyc %0d got %b want %b", i, word_valid_o, m_valid);
            end
        end
        for (int i = 0; i < 29; i++) begin
            drive(1, 1, 1'($urandom), 0, 1, 0);
            tick();
            n_cmp++;
            if (word_valid_o !== m_valid || (m_valid && word_o !== m_word)) begin
                n_bad++; $display("FAIL vn_fill cyc %0d got v=%b %h want v=%b %h", i,
                    word_valid_o, word_o, m_valid, m_word);
            end
        end
        n_cmp++;
        if (word_valid_o !== 1'b1 || word_o[W-1:W-3] !== 3'b011) begin
            n_bad++; $display("FAIL vn_msbs got v=%b %b want v=1 011", word_valid_o, word_o[W-1:W-3]);
        end
        drive(1, 0, 0, 0, 1, 0);
        tick();
    endtask

    task automatic test_backpressure();
        bit [W-1:0] w1, w2;
        for (int i = 0; i < 64; i++) begin
            bit b = 1'($urandom);
            if (i < 32) w1[W-1-i] = b; else w2[W-1-(i-32)] = b;
            drive(1, 1, b, 0, 0, 0);
            tick();
            n_cmp++;
            if (word_valid_o !== m_valid || overflow_o !== m_ovf || (m_valid && word_o !== m_word)) begin
                n_bad++; $display("FAIL bp_hold cyc %0d got v=%b o=%b %h want v=%b o=%b %h", i,
                    word_valid_o, overflow_o, word_o, m_valid, m_ovf, m_word);
            end
        end
        n_cmp++;
        if (word_o !== w1 || overflow_o !== 1'b0) begin
            n_bad++; $display("FAIL bp_first got %h o=%b want %h o=0", word_o, overflow_o, w1);
        end
        drive(1, 1, 1'($urandom), 0, 0, 0);
        tick();
        n_cmp++;
        if (overflow_o !== 1'b1) begin n_bad++; $display("FAIL bp_ovf got %b want 1", overflow_o); end
        drive(1, 0, 0, 0, 1, 0);
        tick();
        n_cmp++;
        if (word_valid_o !== 1'b1 || word_o !== w2) begin
            n_bad++; $display("FAIL bp_drain2 got v=%b %h want v=1 %h", word_valid_o, word_o, w2);
        end
        tick();
        n_cmp++;
        if (word_valid_o !== 1'b0) begin n_bad++; $display("FAIL bp_empty got %b want 0", word_valid_o); end
        drive(1, 0, 0, 0, 1, 1);
        tick();
        n_cmp++;
        if (overflow_o !== 1'b0) begin n_bad++; $display("FAIL bp_clear got %b want 0", overflow_o); end
        drive(1, 0, 0, 0, 1, 0);
    endtask

    task automatic test_simul_drain();
        bit [W-1:0] w2;
        bit bnew;
        for (int i = 0; i < 64; i++) begin
            bit b = 1'($urandom);
            if (i >= 32) w2[W-1-(i-32)] = b;
            drive(1, 1, b, 0, 0, 0);
            tick();
        end
        bnew = 1'($urandom);
        drive(1, 1, bnew, 0, 1, 0);
        tick();
        n_cmp++;
        if (word_valid_o !== 1'b1 || word_o !== w2 || overflow_o !== 1'b0) begin
            n_bad++; $display("FAIL sim_xfer got v=%b %h o=%b want v=1 %h o=0",
                word_valid_o, word_o, overflow_o, w2);
        end
        for (int i = 0; i < 31; i++) begin
            drive(1, 1, 1'($urandom), 0, 1, 0);
            tick();
            n_cmp++;
            if (word_valid_o !== m_valid || (m_valid && word_o !== m_word)) begin
                n_bad++; $display("FAIL sim_next cyc %0d got v=%b %h want v=%b %h", i,
                    word_valid_o, word_o, m_valid, m_word);
            end
        end
        n_cmp++;
        if (word_valid_o !== 1'b1 || word_o[W-1] !== bnew) begin
            n_bad++; $display("FAIL sim_msb got v=%b %b want v=1 %b", word_valid_o, word_o[W-1], bnew);
        end
        drive(1, 0, 0, 0, 1, 0);
        tick();
    endtask

    task automatic test_health();
        int seen = 0;
        drive(1, 0, 0, 0, 1, 1);
        tick();
        for (int i = 0; i < 72; i++) begin
            drive(1, 1, 1, 0, 1, 0);
            tick();
            n_cmp++;
            if ({word_valid_o, alarm_o} !== {m_valid, m_alarm} || (m_valid && word_o !== m_word)) begin
                n_bad++; $display("FAIL hl_run cyc %0d got v=%b a=%b %h want v=%b a=%b %h", i,
                    word_valid_o, alarm_o, word_o, m_valid, m_alarm, m_word);
            end
        end
`ifdef TRNG_HEALTH_TEST_EN
        n_cmp++;
        if (alarm_o !== 1'b1 || word_valid_o !== 1'b0) begin
            n_bad++; $display("FAIL hl_trip got a=%b v=%b want a=1 v=0", alarm_o, word_valid_o);
        end
`else
        n_cmp++;
        if (alarm_o !== 1'b0) begin n_bad++; $display("FAIL hl_off got %b want 0", alarm_o); end
`endif
        drive(1, 0, 0, 0, 1, 1);
        tick();
        for (int i = 0; i < 40; i++) begin
            drive(1, 1, i[0], 0, 1, 0);
            tick();
            if (word_valid_o === 1'b1) seen++;
            n_cmp++;
            if ({word_valid_o, alarm_o} !== {m_valid, m_alarm} || (m_valid && word_o !== m_word)) begin
                n_bad++; $display("FAIL hl_resume cyc %0d got v=%b a=%b %h want v=%b a=%b %h", i,
                    word_valid_o, alarm_o, word_o, m_valid, m_alarm, m_word);
            end
        end
        n_cmp++;
        if (seen == 0) begin n_bad++; $display("FAIL hl_packing got 0 words want >0"); end
    endtask

    task automatic test_random();
        logic vn = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 150 == 0) vn = 1'($urandom);
            drive($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7, 1'($urandom),
                  vn, 1'($urandom), $urandom_range(0, 49) == 0);
            tick();
            n_cmp++;
            if ({word_valid_o, overflow_o, alarm_o} !== {m_valid, m_ovf, m_alarm} ||
                (m_valid && word_o !== m_word)) begin
                n_bad++; $display("FAIL rnd cyc %0d got v=%b o=%b a=%b %h want v=%b o=%b a=%b %h", i,
                    word_valid_o, overflow_o, alarm_o, word_o, m_valid, m_ovf, m_alarm, m_word);
            end
        end
        drive(1, 0, 0, 0, 1, 1);
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        bit [W-1:0] w;
        for (int i = 0; i < 37; i++) begin
            drive(1, 1, 1'($urandom), 0, 0, 0);
            tick();
        end
        n_cmp++;
        if (word_valid_o !== 1'b1) begin n_bad++; $display("FAIL rm_pre got %b want 1", word_valid_o); end
        #3 rst_i = 1'b1;
        #1;
        n_cmp++;
        if ({word_valid_o, word_o, overflow_o, alarm_o} !== '0) begin
            n_bad++; $display("FAIL rm_async got v=%b %h o=%b a=%b want all 0",
                word_valid_o, word_o, overflow_o, alarm_o);
        end
        tick();
        rst_i = 1'b0;
        for (int i = 0; i < 32; i++) begin
            bit b = 1'($urandom);
            w[W-1-i] = b;
            drive(1, 1, b, 0, 1, 0);
            tick();
        end
        n_cmp++;
        if (word_valid_o !== 1'b1 || word_o !== w) begin
            n_bad++; $display("FAIL rm_fresh got v=%b %h want v=1 %h", word_valid_o, word_o, w);
        end
    endtask

    initial begin
        rst_i = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        model_reset();
        tick();
        tick();
        rst_i = 1'b0;
        test_reset();
        test_raw_pack();
        test_debias();
        test_backpressure();
        test_simul_drain();
        test_health();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
